dma_mem_responder: RTL and testbench



---
 rtl/dma_mem_responder_pkg.sv | 43 ++++
 rtl/dma_mem_responder_if.sv | 35 +++
 rtl/dma_mem_responder_fifo.sv | 82 ++++++++
 rtl/dma_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dma_mem_responder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dma_mem_pkg
// Shared types and defaults for the DMA memory responder slice:
//   - state_e       : responder FSM states (IDLE / WAIT / RESP)
//   - req_t         : queued request tuple {write, addr, wdata}
//   - REQ_ZERO      : all-zero request used for resets and defaults
//   - addr_in_range : true when an address lies inside a 2**idx_w word memory
// -----------------------------------------------------------------------------
package dma_mem_pkg;

    localparam int DMA_ADDR_W = 32'sd16;
    localparam int DMA_DATA_W = 32'sd32;
    localparam int DEF_DEPTH  = 32'sd256;
    localparam int DEF_LAT    = 32'sd2;
    localparam int DEF_FIFO_D = 32'sd4;
    // Latency counter width; covers LAT = 0..15.
    localparam int CNT_W      = 32'sd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_DATA_W-1:0] wdata;
    } req_t;

    localparam req_t REQ_ZERO = '{
        write: 1'b0,
        addr:  {DMA_ADDR_W{1'b0}},
        wdata: {DMA_DATA_W{1'b0}}
    };

    // Every address bit at or above idx_w must be clear for the word to exist.
    function automatic logic addr_in_range(input logic [DMA_ADDR_W-1:0] addr,
                                           input int                    idx_w);
        return ((addr >> idx_w) == {DMA_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// -----------------------------------------------------------------------------
// dma_mem_responder_if
// Request/response bus between the DMA controller (master) and the memory
// responder (slave).
//   req_valid / req_ready / req_write / req_addr / req_wdata : request channel
//   rsp_valid / rsp_ready / rsp_rdata / rsp_err              : response channel
// -----------------------------------------------------------------------------
interface dma_mem_responder_if
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dma_mem_responder_fifo.sv
// -----------------------------------------------------------------------------
// dma_req_fifo
// Synchronous in-order queue of req_t entries.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the queue)
//   push       : write push_data when not full
//   push_data  : entry to enqueue
//   pop        : drop the head entry when not empty
//   head       : current head entry (valid while !empty)
//   full/empty : occupancy flags, decoded from the registered count
//   count      : registered occupancy
// -----------------------------------------------------------------------------
module dma_req_fifo
    import dma_mem_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  req_t                   push_data,
    input  logic                   pop,
    output req_t                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 32'sd1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    req_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_r == FULL_C);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Qualify push/pop against the registered flags.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= REQ_ZERO;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/dma_mem_responder.sv
// -----------------------------------------------------------------------------
// dma_mem_responder
// Memory-side DMA responder: queues requests, executes them in order against
// an internal word-addressed memory after LAT cycles, returns one response
// per request.
//   clk   : clock
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : dma_mem_responder_if.slave (request and response channels)
//   busy  : queue non-empty or FSM not IDLE
// Build option DMA_MEM_ERR_EN: addresses >= DEPTH answer with rsp_err = 1,
// rdata = 0, and writes to them are dropped. Without it addresses wrap
// modulo DEPTH and rsp_err stays 0.
// -----------------------------------------------------------------------------
module dma_mem_responder
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LAT    = DEF_LAT,
    parameter int FIFO_D = DEF_FIFO_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_mem_responder_if.slave    bus,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(FIFO_D) + 32'sd1;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    state_e            state_r;
    state_e            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    req_t              cur_req_r;
    req_t              push_data_s;
    req_t              head_s;
    req_t              exec_req_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FC_W-1:0]   fifo_count_s;
    logic [FC_W-1:0]   fifo_count_next_s;
    logic              accept_s;
    logic              pop_s;
    logic              enter_resp_s;
    logic              range_err_s;
    logic              err_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              rsp_valid_next_s;
    logic [DATA_W-1:0] rsp_rdata_next_s;
    logic              rsp_err_next_s;
    logic              busy_next_s;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              busy_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // req_ready depends only on the registered occupancy.
    assign bus.req_ready = !fifo_full_s;
    assign accept_s      = bus.req_valid && !fifo_full_s;

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign busy          = busy_r;

    // Pack the incoming request into a queue entry.
    always_comb begin
        push_data_s       = REQ_ZERO;
        push_data_s.write = bus.req_write;
        push_data_s.addr  = DMA_ADDR_W'(bus.req_addr);
        push_data_s.wdata = DMA_DATA_W'(bus.req_wdata);
    end

    dma_req_fifo #(
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // FSM state, latency counter and the popped request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            cur_req_r <= REQ_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            if (pop_s) begin
                cur_req_r <= head_s;
            end
        end
    end

    // Next-state and latency-counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    cnt_next_s = LAT_C;
                    if (LAT_C == 4'd0) begin
                        next_state_s = RESP;
                    end else begin
                        next_state_s = WAIT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Execution and next values of the registered outputs.
    always_comb begin
        pop_s = (state_r == IDLE) && !fifo_empty_s;
        // With LAT == 0 the head executes on the same edge it is popped.
        if (state_r == IDLE) begin
            exec_req_s = head_s;
        end else begin
            exec_req_s = cur_req_r;
        end
        enter_resp_s = (next_state_s == RESP) && (state_r != RESP);
        mem_idx_s    = exec_req_s.addr[IDX_W-1:0];
        range_err_s  = !addr_in_range(exec_req_s.addr, IDX_W);
`ifdef DMA_MEM_ERR_EN
        err_s = range_err_s;
`else
        err_s = 1'b0;
`endif
        mem_we_s  = enter_resp_s && exec_req_s.write && !err_s;
        rd_word_s = mem_r[mem_idx_s];

        rsp_valid_next_s = (next_state_s == RESP);
        if (enter_resp_s) begin
            rsp_err_next_s = err_s;
            if (exec_req_s.write || err_s) begin
                rsp_rdata_next_s = {DATA_W{1'b0}};
            end else begin
                rsp_rdata_next_s = rd_word_s;
            end
        end else begin
            rsp_err_next_s   = rsp_err_r;
            rsp_rdata_next_s = rsp_rdata_r;
        end

        fifo_count_next_s = fifo_count_s + FC_W'(accept_s) - FC_W'(pop_s);
        busy_next_s       = (fifo_count_next_s != {FC_W{1'b0}}) || (next_state_s != IDLE);
    end

`ifndef DMA_MEM_ERR_EN
    // The range check only feeds the error path of the error-enabled build.
    logic unused_range_s;
    assign unused_range_s = range_err_s;
`endif

    // Registered response channel and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
            rsp_err_r   <= rsp_err_next_s;
            busy_r      <= busy_next_s;
        end
    end

    // Memory array: intentionally not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= DATA_W'(exec_req_s.wdata);
        end
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int FIFO_D = 4;

`ifdef DMA_MEM_ERR_EN
    localparam logic [31:0] EXP_WRAP_RD  = 32'h0000_0000;
    localparam logic        EXP_WRAP_ERR = 1'b1;
    localparam logic [31:0] EXP_MEM5     = 32'hCAFE_0005;
`else
    localparam logic [31:0] EXP_WRAP_RD  = 32'hCAFE_0005;
    localparam logic        EXP_WRAP_ERR = 1'b0;
    localparam logic [31:0] EXP_MEM5     = 32'h1111_1111;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;

    dma_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dma_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LAT    (LAT),
        .FIFO_D (FIFO_D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_pushed = 0;
    int   n_seen   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Response monitor: sampled mid-cycle, a valid&&ready here completes on the next edge.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            chkb("rsp_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chkb("rsp_err", bus.rsp_err, e.err);
                n_seen++;
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, record its expected response.
    task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chkb("req_accept_bound", (n < 100), 1'b1);
        if (n < 100) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chkb(tag, (n < 100), 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chkb("drain_bound", (n < 300), 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 32'h0000_0000;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chkb("rst_req_ready", bus.req_ready, 1'b1);
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chkb("rst_rsp_err", bus.rsp_err, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chkb("idle_busy", busy, 1'b0);
        chkb("idle_req_ready", bus.req_ready, 1'b1);

        // Write then read 0x0010, with latency checks on the write
        bus.rsp_ready = 1'b1;
        send(1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chkb("lat_edge_k", bus.rsp_valid, 1'b0);
        chkb("busy_after_accept", busy, 1'b1);
        @(negedge clk);
        chkb("lat_edge_k1", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chkb("lat_edge_k2", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chkb("lat_edge_k3", bus.rsp_valid, 1'b1);
        send(1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        drain();

        // Preload a few words
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 16'(16'h0020 + i), 32'(32'h1000_0020 + i), 32'h0, 1'b0);
        end
        send(1'b1, 16'h0005, 32'hCAFE_0005, 32'h0, 1'b0);
        drain();

        // Stalled response holds stable for 7 cycles
        bus.rsp_ready = 1'b0;
        send(1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_valid("stall_valid_bound");
        for (int c = 0; c < 7; c++) begin
            chkb("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            chkb("stall_err", bus.rsp_err, 1'b0);
            @(negedge clk);
        end

        // Backpressure: queue fills to FIFO_D behind the stalled response
        for (int i = 0; i < 4; i++) begin
            chkb("bp_ready_before", bus.req_ready, 1'b1);
            send(1'b0, 16'(16'h0020 + i), 32'h0, 32'(32'h1000_0020 + i), 1'b0);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        for (int c = 0; c < 6; c++) begin
            chkb("bp_ready_full", bus.req_ready, 1'b0);
            chkb("bp_valid_held", bus.rsp_valid, 1'b1);
            @(negedge clk);
        end
        chk("bp_single_delivery", 32'(n_seen), 32'(n_pushed - 5));
        bus.rsp_ready = 1'b1;
        send(1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        drain();

        // Out-of-range address 0x0105
        send(1'b0, 16'h0105, 32'h0, EXP_WRAP_RD, EXP_WRAP_ERR);
        send(1'b1, 16'h0105, 32'h1111_1111, 32'h0, EXP_WRAP_ERR);
        send(1'b0, 16'h0005, 32'h0, EXP_MEM5, 1'b0);
        drain();

        // Asynchronous reset while in WAIT with 3 entries queued
        bus.rsp_ready = 1'b0;
        send(1'b0, 16'h0020, 32'h0, 32'h1000_0020, 1'b0);
        wait_valid("rst_setup_valid_bound");
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 16'(16'h0021 + i), 32'h0, 32'h0, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chkb("pre_rst_valid", bus.rsp_valid, 1'b0);
        chkb("pre_rst_busy", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chkb("mid_rst_valid", bus.rsp_valid, 1'b0);
        chkb("mid_rst_busy", busy, 1'b0);
        chkb("mid_rst_ready", bus.req_ready, 1'b1);
        chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
        n_pushed = n_pushed - sb.size();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        send(1'b0, 16'h0005, 32'h0, EXP_MEM5, 1'b0);
        drain();

        chk("resp_count", 32'(n_seen), 32'(n_pushed));
        chkb("sb_empty", (sb.size() == 0), 1'b1);
        chkb("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
